// File: rtl/qif_neuron_array.sv
// Time-multiplexed quadratic integrate-and-fire neuron array.
// One channel is updated per enabled cycle, round-robin, with registered outputs.
module qif_neuron_array #(
  parameter int N_CH     = 4,
  parameter int WIDTH    = 8,
  parameter int SQ_SHIFT = 8,
  parameter int REFRAC   = 2
) (
  input  logic                    clk,
  input  logic                    rst,
  input  logic                    en,
  input  logic                    b_valid,
  input  logic [$clog2(N_CH)-1:0] b_ch,
  input  logic [WIDTH-1:0]        b_in,
  input  logic [WIDTH-1:0]        thresh,
  input  logic [WIDTH-1:0]        v_reset,
  input  logic [WIDTH-1:0]        leak,
  output logic [WIDTH-1:0]        v_out,
  output logic [$clog2(N_CH)-1:0] v_ch,
  output logic                    v_valid,
  output logic [N_CH-1:0]         spike_out
);

  localparam int CW = $clog2(N_CH);
  localparam int SW = 2*WIDTH+2;
  localparam int PW = SW-WIDTH;

  localparam logic signed [SW-1:0] MAXV =
    {{PW{1'b0}}, {WIDTH{1'b1}}};

  logic [WIDTH-1:0] r_v    [N_CH];
  logic [WIDTH-1:0] r_b    [N_CH];
  logic [3:0]       r_rcnt [N_CH];
  logic [CW-1:0]    r_ptr;

  logic [WIDTH-1:0] r_v_out;
  logic [CW-1:0]    r_v_ch;
  logic             r_v_valid;
  logic [N_CH-1:0]  r_spike;

  logic signed [SW-1:0] w_vz;
  logic signed [SW-1:0] w_bz;
  logic signed [SW-1:0] w_lz;
  logic signed [SW-1:0] w_sq;
  logic signed [SW-1:0] w_s;
  logic [WIDTH-1:0]     w_vc;
  logic                 w_refr;
  logic                 w_spk;
  logic [WIDTH-1:0]     w_vnew;
  logic [N_CH-1:0]      w_onehot;

  assign w_vz = {{PW{1'b0}}, r_v[r_ptr]};
  assign w_bz = {{PW{1'b0}}, r_b[r_ptr]};
  assign w_lz = {{PW{1'b0}}, leak};
  assign w_sq = (w_vz * w_vz) >>> SQ_SHIFT;
  assign w_s  = w_vz + w_sq + w_bz - w_lz;

  // Clamp the full-precision sum into the unsigned membrane range.
  always_comb begin
    w_vc = w_s[WIDTH-1:0];
    if (w_s[SW-1])
      w_vc = '0;
    else if (w_s > MAXV)
      w_vc = {WIDTH{1'b1}};
  end

  assign w_refr   = (r_rcnt[r_ptr] != 4'd0);
  assign w_spk    = !w_refr && (w_vc >= thresh);
  assign w_vnew   = (w_refr || w_spk) ? v_reset : w_vc;
  assign w_onehot = {{(N_CH-1){1'b0}}, 1'b1} << r_ptr;

  // Per-channel state: input currents, membranes, refractory counters, pointer.
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      for (int i = 0; i < N_CH; i++) begin
        r_v[i]    <= '0;
        r_b[i]    <= '0;
        r_rcnt[i] <= '0;
      end
      r_ptr <= '0;
    end else begin
      if (b_valid)
        r_b[b_ch] <= b_in;
      if (en) begin
        r_v[r_ptr] <= w_vnew;
        if (w_refr)
          r_rcnt[r_ptr] <= r_rcnt[r_ptr] - 4'd1;
        else if (w_spk)
          r_rcnt[r_ptr] <= 4'(REFRAC);
        r_ptr <= r_ptr + CW'(1);
      end
    end
  end

  // Registered result of the channel updated in the previous cycle.
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      r_v_out   <= '0;
      r_v_ch    <= '0;
      r_v_valid <= 1'b0;
      r_spike   <= '0;
    end else begin
      r_v_valid <= en;
      r_spike   <= (en && w_spk) ? w_onehot : '0;
      if (en) begin
        r_v_out <= w_vnew;
        r_v_ch  <= r_ptr;
      end
    end
  end

  assign v_out     = r_v_out;
  assign v_ch      = r_v_ch;
  assign v_valid   = r_v_valid;
  assign spike_out = r_spike;

endmodule

// File: tb/tb_qif_neuron_array.sv
// Directed self-checking bench for qif_neuron_array.
// Expected values are hand-computed from the QIF update equation.
module tb_qif_neuron_array;

  logic       clk = 1'b0;
  logic       rst = 1'b1;
  logic       en = 1'b0;
  logic       b_valid = 1'b0;
  logic [1:0] b_ch = '0;
  logic [7:0] b_in = '0;
  logic [7:0] thresh = 8'd200;
  logic [7:0] v_reset = 8'd0;
  logic [7:0] leak = 8'd0;
  logic [7:0] v_out;
  logic [1:0] v_ch;
  logic       v_valid;
  logic [3:0] spike_out;

  int ncmp = 0;
  int nerr = 0;
  int cyc = 0;

  qif_neuron_array #(
    .N_CH(4), .WIDTH(8), .SQ_SHIFT(8), .REFRAC(2)
  ) dut (
    .clk(clk), .rst(rst), .en(en),
    .b_valid(b_valid), .b_ch(b_ch), .b_in(b_in),
    .thresh(thresh), .v_reset(v_reset), .leak(leak),
    .v_out(v_out), .v_ch(v_ch), .v_valid(v_valid),
    .spike_out(spike_out)
  );

  always #5 clk = ~clk;

  task automatic step();
    @(posedge clk);
    #1;
    cyc++;
  endtask

  task automatic chk(input string tag,
                     input logic [31:0] obs,
                     input logic [31:0] exp);
    ncmp++;
    assert (obs === exp) else begin
      nerr++;
      $error("FAIL %s observed=%0d expected=%0d",
             tag, obs, exp);
    end
  endtask

  task automatic wr_b(input logic [1:0] c,
                      input logic [7:0] val);
    b_valid = 1'b1;
    b_ch = c;
    b_in = val;
    step();
    b_valid = 1'b0;
  endtask

  task automatic next_upd(input string tag,
                          input logic [1:0] c);
    int n;
    logic hit;
    n = 0;
    hit = 1'b0;
    while (!hit && n < 20) begin
      step();
      n++;
      hit = v_valid && (v_ch == c);
    end
    ncmp++;
    assert (hit) else begin
      nerr++;
      $error("FAIL %s timeout observed=%0d expected=1",
             tag, hit);
    end
  endtask

  task automatic do_reset();
    en = 1'b0;
    b_valid = 1'b0;
    rst = 1'b1;
    step();
    rst = 1'b0;
    step();
  endtask

  initial begin
    #1;
    chk("rst_vout", 32'(v_out), 0);
    chk("rst_valid", 32'(v_valid), 0);
    chk("rst_spike", 32'(spike_out), 0);
    chk("rst_vch", 32'(v_ch), 0);
    step();
    rst = 1'b0;
    step();

    wr_b(2'd0, 8'd64);
    en = 1'b1;
    cyc = 0;
    next_upd("u1", 2'd0);
    chk("u1_vout", 32'(v_out), 64);
    chk("u1_spk", 32'(spike_out), 0);
    next_upd("u2", 2'd0);
    chk("u2_vout", 32'(v_out), 144);
    next_upd("u3", 2'd0);
    chk("u3_vout", 32'(v_out), 0);
    chk("u3_spk", 32'(spike_out), 1);
    chk("u3_cyc", 32'(cyc), 9);
    next_upd("r1", 2'd0);
    chk("r1_vout", 32'(v_out), 0);
    chk("r1_spk", 32'(spike_out), 0);
    next_upd("r2", 2'd0);
    chk("r2_vout", 32'(v_out), 0);
    chk("r2_spk", 32'(spike_out), 0);
    next_upd("r3", 2'd0);
    chk("r3_vout", 32'(v_out), 64);
    next_upd("c1q", 2'd1);
    chk("ch1_idle", 32'(v_out), 0);

    do_reset();
    wr_b(2'd0, 8'd64);
    en = 1'b1;
    b_valid = 1'b1;
    b_ch = 2'd0;
    b_in = 8'd100;
    step();
    b_valid = 1'b0;
    chk("col_vch", 32'(v_ch), 0);
    chk("col_old", 32'(v_out), 64);
    next_upd("col2", 2'd0);
    chk("col_new", 32'(v_out), 180);
    next_upd("col3", 2'd0);
    chk("col3_spk", 32'(spike_out), 1);
    chk("col3_vout", 32'(v_out), 0);

    do_reset();
    thresh = 8'd255;
    v_reset = 8'd7;
    wr_b(2'd1, 8'd255);
    en = 1'b1;
    step();
    chk("sat_c0", 32'(v_out), 0);
    chk("sat_c0spk", 32'(spike_out), 0);
    next_upd("sat", 2'd1);
    chk("sat_spk", 32'(spike_out), 2);
    chk("sat_vout", 32'(v_out), 7);

    do_reset();
    thresh = 8'd200;
    v_reset = 8'd0;
    leak = 8'd10;
    en = 1'b1;
    next_upd("lk1", 2'd2);
    chk("lk1_vout", 32'(v_out), 0);
    next_upd("lk2", 2'd2);
    chk("lk2_vout", 32'(v_out), 0);
    chk("lk2_spk", 32'(spike_out), 0);
    en = 1'b0;
    step();
    chk("hold_v1", 32'(v_valid), 0);
    step();
    chk("hold_v2", 32'(v_valid), 0);
    chk("hold_spk", 32'(spike_out), 0);
    en = 1'b1;
    step();
    chk("hold_vch", 32'(v_ch), 3);
    chk("hold_vld", 32'(v_valid), 1);

    leak = 8'd0;
    wr_b(2'd0, 8'd50);
    next_upd("mr0", 2'd0);
    chk("mr0_vout", 32'(v_out), 50);
    next_upd("mr1", 2'd1);
    rst = 1'b1;
    #1;
    chk("mr_vout", 32'(v_out), 0);
    chk("mr_valid", 32'(v_valid), 0);
    chk("mr_vch", 32'(v_ch), 0);
    step();
    rst = 1'b0;
    step();
    chk("mr_ptr_vch", 32'(v_ch), 0);
    chk("mr_ptr_vld", 32'(v_valid), 1);
    chk("mr_ptr_vout", 32'(v_out), 0);

    en = 1'b0;
    $display("*** SUMMARY: %0d compared / %0d mismatched ***",
             ncmp, nerr);
    $finish;
  end

endmodule
